maze_path_walker: RTL and testbench

- Parametrised next-generation maze solver.
- Loads a DIM x DIM cell map serially, then removes dead ends in parallel until the map is stable.
- Walks the surviving path from (0,0) to (DIM-1,DIM-1), emitting one direction code per cycle, then reports the path length.
- Sits between the map-input stage and the path-consumer/scoring stage; adds configurable size, no-path detection, step-limit abort and load-abort, none of which the fixed 17x17 generation had.

---
 rtl/maze_pkg.sv | 24 ++
 rtl/maze_path_walker_if.sv | 14 +
 rtl/maze_cell_array.sv | 71 +++++++
 rtl/maze_path_walker.sv | 136 +++++++++++++
 tb/tb_maze_path_walker.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared cell/direction codes and FSM state encoding for the maze path walker.
package maze_pkg;
  localparam logic [1:0] CELL_WALL = 2'd0;
  localparam logic [1:0] CELL_PATH = 2'd1;
  localparam logic [1:0] CELL_TRAP = 2'd2;
  localparam logic [1:0] CELL_MARK = 2'd3;

  localparam logic [2:0] DIR_R     = 3'd0;
  localparam logic [2:0] DIR_D     = 3'd1;
  localparam logic [2:0] DIR_L     = 3'd2;
  localparam logic [2:0] DIR_U     = 3'd3;
  localparam logic [2:0] DIR_STALL = 3'd4;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_PRUNE, ST_WALK, ST_DONE} state_t;

  function automatic logic passable(input logic [1:0] c);
    return (c == CELL_PATH) || (c == CELL_MARK) || (c == CELL_TRAP);
  endfunction

  // At most one open side means three or more sides are blocked.
  function automatic logic dead_end(input logic [3:0] o);
    return (o & (o - 4'd1)) == 4'd0;
  endfunction
endpackage

// File: rtl/maze_path_walker_if.sv
// Map-input / path-output bundle between the map producer and the walker.
interface maze_path_walker_if #(parameter int LW = 10);
  logic          in_valid;
  logic [1:0]    in;
  logic          busy;
  logic          out_valid;
  logic [2:0]    out;
  logic          out_done;
  logic [LW-1:0] out_len;
  logic          err;

  modport master (output in_valid, in, input busy, out_valid, out, out_done, out_len, err);
  modport slave  (input in_valid, in, output busy, out_valid, out, out_done, out_len, err);
endinterface

// File: rtl/maze_cell_array.sv
// DIM x DIM cell store with raster write port, single-cycle parallel dead-end prune and a neighbour query.
module maze_cell_array import maze_pkg::*; #(
  parameter int DIM = 17,
  parameter int CW  = $clog2(DIM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_x,
  input  logic [CW-1:0] wr_y,
  input  logic [1:0]    wr_cell,
  input  logic          prune_en,
  input  logic [CW-1:0] qx,
  input  logic [CW-1:0] qy,
  output logic          changed,
  output logic [3:0]    q_open,
  output logic [1:0]    q_cell
);
  logic [DIM-1:0][DIM-1:0][1:0] cells;
  logic [DIM-1:0][DIM-1:0]      pass, kill;
  logic [DIM-1:0][DIM-1:0][3:0] open;

  // open bits per cell: [0] right, [1] down, [2] left, [3] up; border reads as blocked
  for (genvar gy = 0; gy < DIM; gy++) begin : g_row
    for (genvar gx = 0; gx < DIM; gx++) begin : g_col
      assign pass[gy][gx] = passable(cells[gy][gx]);
      if (gx < DIM-1) begin : g_r
        assign open[gy][gx][0] = pass[gy][gx+1];
      end else begin : g_rb
        assign open[gy][gx][0] = 1'b0;
      end
      if (gy < DIM-1) begin : g_d
        assign open[gy][gx][1] = pass[gy+1][gx];
      end else begin : g_db
        assign open[gy][gx][1] = 1'b0;
      end
      if (gx > 0) begin : g_l
        assign open[gy][gx][2] = pass[gy][gx-1];
      end else begin : g_lb
        assign open[gy][gx][2] = 1'b0;
      end
      if (gy > 0) begin : g_u
        assign open[gy][gx][3] = pass[gy-1][gx];
      end else begin : g_ub
        assign open[gy][gx][3] = 1'b0;
      end
      if ((gx == 0 && gy == 0) || (gx == DIM-1 && gy == DIM-1)) begin : g_keep
        assign kill[gy][gx] = 1'b0;
      end else begin : g_kill
        assign kill[gy][gx] = pass[gy][gx] & dead_end(open[gy][gx]);
      end
    end
  end

  assign changed = prune_en & (|kill);
  assign q_open  = open[qy][qx];
  assign q_cell  = cells[qy][qx];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cells <= '0;
    end else if (wr_en) begin
      cells[wr_y][wr_x] <= wr_cell;
    end else if (prune_en) begin
      for (int y = 0; y < DIM; y++)
        for (int x = 0; x < DIM; x++)
          if (kill[y][x]) cells[y][x] <= CELL_WALL;
    end
  end
endmodule

// File: rtl/maze_path_walker.sv
// Serial map load, parallel dead-end pruning, then a priority walk from (0,0) to (DIM-1,DIM-1).
module maze_path_walker import maze_pkg::*; #(
  parameter int DIM = 17,
  parameter int CW  = $clog2(DIM),
  parameter int LW  = 10
) (
  input logic              clk,
  input logic              rst_n,
  maze_path_walker_if.slave bus
);
  localparam logic [CW-1:0] LAST = CW'(DIM-1);
  localparam logic [LW-1:0] LIM  = '1;

  state_t        state;
  logic [CW-1:0] lx, ly, px, py, nx, ny, wr_x, wr_y;
  logic [2:0]    last_dir, dir, walk_dir;
  logic [3:0]    q_open, rev, avail;
  logic [1:0]    q_cell, wr_cell;
  logic [LW-1:0] moves;
  logic          stalled, err_flag, abort_pulse, changed;
  logic          stall_now, arrive, wr_en, clr, prune_en;

  assign wr_en    = (state == ST_IDLE || state == ST_LOAD) && bus.in_valid;
  assign wr_x     = (state == ST_LOAD) ? lx : '0;
  assign wr_y     = (state == ST_LOAD) ? ly : '0;
  assign wr_cell  = ((wr_x == '0 && wr_y == '0) || (wr_x == LAST && wr_y == LAST)) ? CELL_PATH : bus.in;
  assign clr      = (state == ST_LOAD) && !bus.in_valid;
  assign prune_en = (state == ST_PRUNE);

  maze_cell_array #(.DIM(DIM), .CW(CW)) u_cells (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_cell(wr_cell),
    .prune_en(prune_en), .qx(px), .qy(py),
    .changed(changed), .q_open(q_open), .q_cell(q_cell)
  );

  // Reversal is excluded; fall back to it only when nothing else is open.
  always_comb begin
    rev   = last_dir[2] ? 4'b0000 : (4'b0001 << {~last_dir[1], last_dir[0]});
    avail = q_open & ~rev;
    if (avail == 4'b0000) avail = q_open;
    if (avail[0])      dir = DIR_R;
    else if (avail[1]) dir = DIR_D;
    else if (avail[2]) dir = DIR_L;
    else               dir = DIR_U;
    nx = px;
    ny = py;
    case (dir)
      DIR_R:   nx = px + 1'b1;
      DIR_D:   ny = py + 1'b1;
      DIR_L:   nx = px - 1'b1;
      default: ny = py - 1'b1;
    endcase
    stall_now = (q_cell == CELL_TRAP) && !stalled;
    walk_dir  = stall_now ? DIR_STALL : dir;
    arrive    = !stall_now && nx == LAST && ny == LAST;
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_valid = (state == ST_WALK);
  assign bus.out       = (state == ST_WALK) ? walk_dir : 3'd0;
  assign bus.out_done  = (state == ST_DONE);
  assign bus.out_len   = (state == ST_DONE) ? moves : '0;
  assign bus.err       = ((state == ST_DONE) && err_flag) || abort_pulse;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      lx          <= '0;
      ly          <= '0;
      px          <= '0;
      py          <= '0;
      last_dir    <= DIR_STALL;
      stalled     <= 1'b0;
      moves       <= '0;
      err_flag    <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      abort_pulse <= 1'b0;
      case (state)
        ST_IDLE: if (bus.in_valid) begin
          lx    <= CW'(1);
          ly    <= '0;
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (!bus.in_valid) begin
            abort_pulse <= 1'b1;
            state       <= ST_IDLE;
          end else if (lx == LAST && ly == LAST) begin
            px       <= '0;
            py       <= '0;
            last_dir <= DIR_STALL;
            stalled  <= 1'b0;
            moves    <= '0;
            err_flag <= 1'b0;
            state    <= ST_PRUNE;
          end else if (lx == LAST) begin
            lx <= '0;
            ly <= ly + 1'b1;
          end else begin
            lx <= lx + 1'b1;
          end
        end
        // the query port sits on (0,0) here, so q_open is the start's neighbourhood
        ST_PRUNE: if (!changed) begin
          if (q_open == 4'b0000) begin
            err_flag <= 1'b1;
            state    <= ST_DONE;
          end else begin
            state <= ST_WALK;
          end
        end
        ST_WALK: begin
          if (stall_now) begin
            stalled <= 1'b1;
          end else begin
            px       <= nx;
            py       <= ny;
            last_dir <= dir;
            stalled  <= 1'b0;
            moves    <= moves + 1'b1;
            if (arrive) begin
              state <= ST_DONE;
            end else if (moves == LIM - 1'b1) begin
              err_flag <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maze_path_walker.sv
// Table-driven maze walker bench with a direction scoreboard plus abort/reset sequences.
module tb_maze_path_walker;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  maze_path_walker_if #(.LW(10)) bus5();
  maze_path_walker_if #(.LW(10)) bus4();

  maze_path_walker #(.DIM(5), .LW(10)) u5 (.clk(clk), .rst_n(rst_n), .bus(bus5));
  maze_path_walker #(.DIM(4), .LW(10)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    logic [49:0] map;
    int          n;
    logic [63:0] dirs;   // one nibble per direction, first move in the most significant used nibble
    logic [9:0]  len;
    logic        err;
  } vec_t;

  vec_t       vecs[6];
  logic [2:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  function automatic logic [49:0] setc(input logic [49:0] m, input int x, input int y, input logic [1:0] c);
    m[(y*5+x)*2 +: 2] = c;
    return m;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  task automatic load5(input logic [49:0] m, input int ncells);
    for (int i = 0; i < ncells; i++) begin
      @(negedge clk);
      bus5.in_valid = 1'b1;
      bus5.in       = m[i*2 +: 2];
    end
    @(negedge clk);
    bus5.in_valid = 1'b0;
    bus5.in       = 2'd0;
  endtask

  task automatic watch5(input string nm, input logic [9:0] elen, input logic eerr);
    bit done;
    logic [2:0] e;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (bus5.out_valid) begin
        check({nm, "_busy"}, bus5.busy, 1);
        if (exp_q.size() == 0) fail_now({nm, "_extra_dir"});
        else begin
          e = exp_q.pop_front();
          check({nm, "_dir"}, bus5.out, e);
        end
      end else begin
        check({nm, "_out_idle"}, bus5.out, 0);
      end
      if (bus5.out_done) begin
        check({nm, "_len"}, bus5.out_len, elen);
        check({nm, "_err"}, bus5.err, eerr);
        check({nm, "_drained"}, exp_q.size(), 0);
        done = 1'b1;
      end
    end
    if (!done) fail_now({nm, "_timeout"});
    @(negedge clk);
    check({nm, "_busy_after"}, bus5.busy, 0);
    check({nm, "_done_after"}, bus5.out_done, 0);
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    v = vecs[vi];
    exp_q.delete();
    for (int i = 0; i < v.n; i++) exp_q.push_back(v.dirs[(v.n-1-i)*4 +: 3]);
    load5(v.map, 25);
    watch5($sformatf("vec%0d", vi), v.len, v.err);
  endtask

  initial begin
    logic [49:0] base, m;
    int nv;
    bit hit;

    base = '0;
    for (int x = 0; x < 5; x++) base = setc(base, x, 0, 2'd1);
    for (int y = 1; y < 5; y++) base = setc(base, 4, y, 2'd1);

    vecs[0] = '{base, 8, 64'h11110000 >> 0, 10'd8, 1'b0};
    vecs[0].dirs = 64'h00001111;
    vecs[1] = '{setc(base, 2, 0, 2'd2), 9, 64'h004001111, 10'd8, 1'b0};
    vecs[2] = '{setc(setc(base, 1, 1, 2'd1), 1, 2, 2'd1), 8, 64'h00001111, 10'd8, 1'b0};
    m = '0;
    for (int y = 0; y < 5; y++) m = setc(m, 0, y, 2'd1);
    for (int x = 1; x < 5; x++) m = setc(m, x, 4, 2'd1);
    vecs[3] = '{m, 8, 64'h11110000, 10'd8, 1'b0};
    // marked cells, traps on start/end (forced to path) and two consecutive traps
    m = base;
    for (int x = 1; x < 4; x++) m = setc(m, x, 0, 2'd3);
    m = setc(setc(m, 0, 0, 2'd2), 4, 4, 2'd2);
    m = setc(setc(m, 4, 2, 2'd2), 4, 3, 2'd2);
    vecs[4] = '{m, 10, 64'h0000114141, 10'd8, 1'b0};
    m = '0;
    m = setc(m, 0, 0, 2'd1); m = setc(m, 1, 0, 2'd1); m = setc(m, 2, 0, 2'd1);
    m = setc(m, 2, 1, 2'd1); m = setc(m, 2, 2, 2'd1); m = setc(m, 1, 2, 2'd1);
    m = setc(m, 0, 2, 2'd1); m = setc(m, 0, 3, 2'd1); m = setc(m, 0, 4, 2'd1);
    for (int x = 1; x < 5; x++) m = setc(m, x, 4, 2'd1);
    vecs[5] = '{m, 12, 64'h001122110000, 10'd12, 1'b0};

    rst_n = 1'b0;
    bus5.in_valid = 1'b0; bus5.in = 2'd0;
    bus4.in_valid = 1'b0; bus4.in = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus5.busy, 0);
    check("rst_valid", bus5.out_valid, 0);
    check("rst_out", bus5.out, 0);
    check("rst_done", bus5.out_done, 0);
    check("rst_len", bus5.out_len, 0);
    check("rst_err", bus5.err, 0);
    check("rst4_busy", bus4.busy, 0);
    check("rst4_err", bus4.err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i);

    // load abort after 12 cells, then a normal reload
    load5(base, 12);
    check("abort_busy_load", bus5.busy, 1);
    @(negedge clk);
    check("abort_err", bus5.err, 1);
    check("abort_done", bus5.out_done, 0);
    check("abort_busy", bus5.busy, 0);
    @(negedge clk);
    check("abort_err_clear", bus5.err, 0);
    run_vec(0);

    // DIM=4 with only start/end (trap codes there are ignored): no walk, error completion
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus4.in_valid = 1'b1;
      bus4.in = (i == 0 || i == 15) ? 2'd2 : 2'd0;
    end
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus4.in = 2'd0;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      if (bus4.out_valid) fail_now("nopath_walk_seen");
      if (bus4.out_done) begin
        check("nopath_err", bus4.err, 1);
        check("nopath_len", bus4.out_len, 0);
        hit = 1'b1;
      end
    end
    if (!hit) fail_now("nopath_timeout");
    @(negedge clk);
    check("nopath_busy_after", bus4.busy, 0);

    // reset during the third walk cycle
    load5(base, 25);
    nv = 0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (bus5.out_valid) begin
        check("midrst_dir", bus5.out, 0);
        nv++;
        if (nv == 3) begin
          rst_n = 1'b0;
          hit = 1'b1;
        end
      end
    end
    if (!hit) fail_now("midrst_timeout");
    @(negedge clk);
    check("midrst_busy", bus5.busy, 0);
    check("midrst_valid", bus5.out_valid, 0);
    check("midrst_out", bus5.out, 0);
    check("midrst_done", bus5.out_done, 0);
    check("midrst_len", bus5.out_len, 0);
    check("midrst_err", bus5.err, 0);
    rst_n = 1'b1;
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
